// File: rtl/regfile_mp.sv
// Multi-ported register file with optional write-to-read bypass, hardwired zero
// register and a per-register busy scoreboard for issue/writeback hazard tracking.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_READ*AW-1:0]    raddr,
    output logic [NUM_READ*XLEN-1:0]  rdata,
    output logic [NUM_READ-1:0]       rbusy,
    input  logic [NUM_WRITE-1:0]      wen,
    input  logic [NUM_WRITE*AW-1:0]   waddr,
    input  logic [NUM_WRITE*XLEN-1:0] wdata,
    input  logic                      busy_set_en,
    input  logic [AW-1:0]             busy_set_addr,
    input  logic                      flush
);

    logic [XLEN-1:0]      regs_q [REG_COUNT];
    logic [XLEN-1:0]      regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_COUNT-1:0] wr_hit;

    // An address is architecturally live if in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({{(32-AW){1'b0}}, a} < 32'(REG_COUNT)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Later ports overwrite earlier ones, so the highest enabled port index wins.
    always_comb begin
        logic [AW-1:0] wa;
        wa = '0;
        wr_hit = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            wa = waddr[w*AW +: AW];
            if (wen[w] && addr_ok(wa)) begin
                regs_d[wa] = wdata[w*XLEN +: XLEN];
                wr_hit[wa] = 1'b1;
            end
        end
    end

    // Scoreboard priority: flush over a new producer's set, set over writeback clear.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (busy_set_en && addr_ok(busy_set_addr)) begin
            busy_d[busy_set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        rbusy = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            ra = raddr[r*AW +: AW];
            if (addr_ok(ra)) begin
                rdata[r*XLEN +: XLEN] = regs_q[ra];
                rbusy[r]              = busy_q[ra];
                // A forwarded value is the writeback itself, so it is never busy.
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (wen[w] && (waddr[w*AW +: AW] == ra)) begin
                            rdata[r*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                            rbusy[r]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
